// File: rtl/brdg_retry_pkg.sv
// brdg_retry_pkg: retry-engine FSM states, rsp_typ bit indices, done-table entry type and backoff length helper
package brdg_retry_pkg;
  typedef enum logic [2:0] {IDLE, POP, CHECK, BACKOFF, ISSUE, FAIL} state_t;
  localparam int T_PEND = 0;
  localparam int T_DONE_BO = 1;
  localparam int T_DONE_IMM = 2;
  localparam int T_RTY_BO = 3;
  localparam int T_PART = 4;
  localparam logic [23:0] BACKOFF_UNIT = 24'h14;
  typedef struct packed {
    logic valid;
    logic backoff;
    logic immediate;
  } done_t;
  function automatic logic [23:0] backoff_len(input logic [3:0] e);
    return BACKOFF_UNIT << e;
  endfunction
endpackage

// File: rtl/brdg_retry_engine_if.sv
// brdg_retry_engine_if: response in (rsp_den/pos/tag/typ), completion in (cmp_den/tag), retry out (rty_valid/pos/tag, rty_rdy)
interface brdg_retry_engine_if #(
  parameter int TAGW = 7,
  parameter int POSW = 2
);
  logic rsp_den;
  logic [POSW-1:0] rsp_pos;
  logic [TAGW-1:0] rsp_tag;
  logic [4:0] rsp_typ;
  logic cmp_den;
  logic [TAGW-1:0] cmp_tag;
  logic rty_rdy;
  logic rty_valid;
  logic [POSW-1:0] rty_pos;
  logic [TAGW-1:0] rty_tag;
  modport master (
    output rsp_den, rsp_pos, rsp_tag, rsp_typ, cmp_den, cmp_tag, rty_rdy,
    input rty_valid, rty_pos, rty_tag
  );
  modport slave (
    input rsp_den, rsp_pos, rsp_tag, rsp_typ, cmp_den, cmp_tag, rty_rdy,
    output rty_valid, rty_pos, rty_tag
  );
endinterface

// File: rtl/brdg_sync_fifo.sv
// brdg_sync_fifo: sync FIFO; ports clk, rst, wr_en/wr_data, rd_en/rd_data (registered), full, empty, overflow (drop pulse)
module brdg_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input logic clk,
  input logic rst,
  input logic wr_en,
  input logic [DATA_WIDTH-1:0] wr_data,
  input logic rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic full,
  output logic empty,
  output logic overflow
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {ADDR_WIDTH{1'b0}}};
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wp[ADDR_WIDTH-1:0]] <= wr_data;
    if (rst) begin
      wp <= '0;
      rp <= '0;
      rd_data <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (wr_en && !full) wp <= wp + 1'b1;
      if (rd_en && !empty) begin
        rd_data <= mem[rp[ADDR_WIDTH-1:0]];
        rp <= rp + 1'b1;
      end
    end
  end
endmodule

// File: rtl/brdg_retry_engine.sv
// brdg_retry_engine: retry queue with per-tag backoff; ports clk, rst, backoff_base, max_retry, prt_cmd_start, bus, fail_valid/tag, rty_busy, overflow
module brdg_retry_engine
  import brdg_retry_pkg::*;
#(
  parameter int TAGW = 7,
  parameter int POSW = 2,
  parameter int DEPTH_LOG2 = 7,
  parameter int CNTW = 4
) (
  input logic clk,
  input logic rst,
  input logic [3:0] backoff_base,
  input logic [CNTW-1:0] max_retry,
  input logic prt_cmd_start,
  brdg_retry_engine_if.slave bus,
  output logic fail_valid,
  output logic [TAGW-1:0] fail_tag,
  output logic rty_busy,
  output logic overflow
);
  localparam int DW = TAGW + POSW + 2;
  state_t state;
  logic r_den;
  logic [POSW-1:0] r_pos;
  logic [TAGW-1:0] r_tag;
  logic [4:0] r_typ;
  logic [DW-1:0] ent;
  logic [TAGW-1:0] ent_tag;
  logic [POSW-1:0] ent_pos;
  logic ent_rb;
  logic empty, full, push, dwr, hs, chk, lim, go_bo, go_is, fail_go, consume;
  logic [DEPTH_LOG2:0] pend;
  logic [23:0] cnt;
  logic [CNTW-1:0] rcnt [2**TAGW];
  done_t done_tab [2**TAGW];
  logic [CNTW-1:0] rc;
  done_t dn;
  logic [CNTW+4:0] e_sum;
  logic [3:0] e;
  logic unused;
  assign push = r_den && (r_typ[T_PEND] || r_typ[T_RTY_BO]);
  assign dwr = r_den && (r_typ[T_DONE_BO] || r_typ[T_DONE_IMM]);
  assign {ent_rb, ent_pos, ent_tag} = ent[DW-2:0];
  assign rc = rcnt[ent_tag];
  assign dn = done_tab[ent_tag];
  assign chk = state == CHECK;
  assign lim = max_retry != '0 && rc >= max_retry;
  assign go_bo = ent_rb || (dn.valid && dn.backoff);
  assign go_is = dn.valid && dn.immediate;
  assign fail_go = chk && lim;
  assign consume = chk && !ent_rb && (lim || dn.valid);
  assign hs = bus.rty_valid && bus.rty_rdy;
  assign e_sum = (CNTW+5)'(backoff_base) + (CNTW+5)'(rc);
  assign e = e_sum > 15 ? 4'd15 : e_sum[3:0];
  assign rty_busy = !empty || state != IDLE;
  assign unused = &{1'b0, prt_cmd_start, full, ent[DW-1]};
  brdg_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(DEPTH_LOG2)) u_fifo (
    .clk,
    .rst,
    .wr_en(push),
    .wr_data({r_typ[T_PART], r_typ[T_RTY_BO], r_pos, r_tag}),
    .rd_en(state == POP),
    .rd_data(ent),
    .full,
    .empty,
    .overflow
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_den, r_pos, r_tag, r_typ} <= '0;
      pend <= '0;
      for (int i = 0; i < 2**TAGW; i++) begin
        rcnt[i] <= '0;
        done_tab[i] <= '0;
      end
    end else begin
      {r_den, r_pos, r_tag, r_typ} <= {bus.rsp_den, bus.rsp_pos, bus.rsp_tag, bus.rsp_typ};
      if (r_den && r_typ[T_PEND]) pend <= pend + 1'b1;
      else if (dwr && pend != '0) pend <= pend - 1'b1;
      if (consume) done_tab[ent_tag].valid <= 1'b0;
      if (dwr) done_tab[r_tag] <= '{valid: 1'b1, backoff: r_typ[T_DONE_BO], immediate: r_typ[T_DONE_IMM]};
      if (hs && rcnt[bus.rty_tag] != '1) rcnt[bus.rty_tag] <= rcnt[bus.rty_tag] + 1'b1;
      if (fail_go) rcnt[ent_tag] <= '0;
      if (bus.cmp_den) rcnt[bus.cmp_tag] <= '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.rty_valid <= 1'b0;
      bus.rty_pos <= '0;
      bus.rty_tag <= '0;
      fail_valid <= 1'b0;
      fail_tag <= '0;
    end else begin
      fail_valid <= 1'b0;
      case (state)
        IDLE: if (!empty && pend == '0) state <= POP;
        POP: state <= CHECK;
        CHECK: begin
          state <= lim ? FAIL : go_bo ? BACKOFF : go_is ? ISSUE : CHECK;
          cnt <= backoff_len(e) - 1'b1;
          fail_valid <= lim;
          if (lim) fail_tag <= ent_tag;
          bus.rty_valid <= !lim && !go_bo && go_is;
          bus.rty_pos <= ent_pos;
          bus.rty_tag <= ent_tag;
        end
        BACKOFF: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= ISSUE;
            bus.rty_valid <= 1'b1;
          end
        end
        ISSUE: if (bus.rty_rdy) begin
          state <= IDLE;
          bus.rty_valid <= 1'b0;
        end
        FAIL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/brdg_retry_engine.md
# brdg_retry_engine

Parametrised retry queue for the bridge command path: collects `xlate_pending` and `rty_req` responses, holds them until every outstanding `xlate_pending` has a matching `xlate_done`, then re-issues them one at a time after a per-tag backoff.
- Generalised in tag width, position width and queue depth.
- Tracks a retry count per tag, so the backoff doubles on every repeat.
- Reports a tag as failed once it exceeds a programmable retry limit.
- Sits between the response decoder and the command arbiter's retry input.

## Interface
- `TAGW`, 7, AFU tag width
- `POSW`, 2, position field width
- `DEPTH_LOG2`, 7, log2 of queue depth
- `CNTW`, 4, per-tag retry counter width
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `backoff_base` in 4: base backoff exponent
- `max_retry` in CNTW: retry limit; 0 means unlimited
- `prt_cmd_start` in 1: partial-command start; reserved, ignored
- `rsp_den` in 1: response strobe
- `rsp_pos` in POSW: response position
- `rsp_tag` in TAGW: response tag
- `rsp_typ` in 5: response type, one-hot
  - bit 0: xlate_pending
  - bit 1: xlate_done_backoff
  - bit 2: xlate_done_immediate
  - bit 3: retry_backoff
  - bit 4: partial
- `cmp_den` in 1: successful completion strobe
- `cmp_tag` in TAGW: tag of the successful completion
- `rty_rdy` in 1: arbiter ready
- `rty_valid` out 1: retry request valid
- `rty_pos` out POSW: retry position
- `rty_tag` out TAGW: retry tag
- `fail_valid` out 1: one-cycle retry-limit failure
- `fail_tag` out TAGW: failed tag
- `rty_busy` out 1: queue non-empty or FSM not IDLE
- `overflow` out 1: one-cycle pulse when a push is dropped

## Operation
- **Input stage:** registers `rsp_*`. Push to the FIFO on `rsp_den & (typ[0] | typ[3])`. FIFO entry is `{partial, retry_backoff, pos, tag}`.
- **Done table:** 2^TAGW entries of `{valid, backoff, immediate}`.
  - Written on `rsp_den & (typ[1] | typ[2])`.
  - Entry valid is cleared when the FSM consumes it.
- **Pending counter:** DEPTH_LOG2+1 bits.
  - +1 on xlate_pending.
  - −1 on xlate_done.
  - A decrement at 0 is ignored.
- **Retry counter array:** `rcnt[2^TAGW]` of CNTW bits.
  - Cleared on `cmp_den`.
  - Incremented on issue handshake, saturating.
  - Cleared on fail.
  - When `cmp_den` and an issue on the same tag occur in the same cycle, the clear wins.
- **FSM states and transitions:**
  - **IDLE → POP** when the FIFO is not empty and the pending counter is 0.
  - **POP:** 1 cycle; FIFO read, entry registered.
  - **CHECK:** read `rcnt[tag]` and the done table.
    - If `max_retry != 0` and `rcnt >= max_retry` → FAIL.
    - Else if the entry is retry_backoff, or pending with done.backoff → BACKOFF.
    - Else if pending with done.immediate → ISSUE.
    - Else (pending without a valid done entry) → stay in CHECK.
  - **BACKOFF:**
    - Countdown loaded with N−1, where N = 24'h14 << e and e = min(backoff_base + rcnt, 15).
    - → ISSUE when the count reaches 0.
  - **ISSUE:**
    - `rty_valid` = 1; pos and tag are held stable.
    - → IDLE on `rty_valid & rty_rdy`.
  - **FAIL:** `fail_valid` = 1 for one cycle → IDLE.
- **Overflow:** a push while the FIFO is full is dropped and pulses `overflow`.

## Timing
- **Reset values:** all outputs 0, FSM IDLE, FIFO empty, pending counter 0, done table invalid, `rcnt` all 0. Reset asserted in any state takes effect at the next edge, and outputs are 0 in the following cycle.
- **Push latency:** `rsp_den` at cycle t gives a FIFO write at the t+1 edge; the FIFO reads non-empty from t+2.
- **Issue latency:**
  - Immediate path: POP at T, CHECK at T+1, `rty_valid` at T+2.
  - Backoff path: exactly N cycles in BACKOFF, then ISSUE.
- **Handshake:** standard valid/ready. `rty_valid` does not depend on `rty_rdy`.
- **Ordering:** retries issue in FIFO order; one retry is in flight at a time.

## Structure
- **Package `brdg_retry_pkg`:**
  - FSM state enum.
  - `rsp_typ` bit-index constants.
  - `BACKOFF_UNIT = 24'h14`.
- **Sub-module `brdg_sync_fifo`:** parametrised DATA_WIDTH/ADDR_WIDTH, synchronous active-high reset, registered read data, and full/empty/overflow outputs.
- **Top level:** done table and `rcnt` array are plain register arrays in the top level.

## Test plan
- **Retry backoff, cnt 0:** retry_backoff tag 5 pos 1, `backoff_base` = 0 → `rty_valid` with tag 5 pos 1 at POP+2+20, held until `rty_rdy`.
- **Pending then immediate done:** xlate_pending tag 3, then xlate_done_immediate tag 3 ten cycles later → no POP before the done arrives; `rty_valid` 2 cycles after POP.
- **Backoff escalation:** tag 7 re-queued three times with `backoff_base` = 2 → BACKOFF lengths 80, 160, 320 cycles. Then `cmp_den` tag 7 plus a new retry → 80.
- **Retry limit:** `max_retry` = 2, tag 9 queued a third time → `fail_valid` for 1 cycle with `fail_tag` = 9, no `rty_valid`, `rcnt[9]` = 0.
- **Overflow:** 129 pushes with `rty_rdy` low → `overflow` pulses once; 128 retries are later issued in push order.
- **Reset mid-backoff:** `rst` asserted during BACKOFF → next cycle `rty_valid`, `rty_busy` and `fail_valid` are 0; no retry is issued afterwards.
